// File: rtl/bit_reorder_stream_if.sv
// Valid/ready stream bundle for bit_reorder_stream: one input beat channel and one output beat channel.
// The master drives input beats and output acceptance. The slave (the reorder block) drives the rest.
interface bit_reorder_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/bit_reorder_stream.sv
// Registered, runtime-programmable bit permutation on a valid/ready stream: out[i] = in[map[i]].
// Define BIT_REORDER_INVERT_EN to add the cfg_inv port and a per-output-bit inversion table.
module bit_reorder_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 cfg_wr,
  input  logic [SEL_WIDTH-1:0] cfg_idx,
  input  logic [SEL_WIDTH-1:0] cfg_sel,
`ifdef BIT_REORDER_INVERT_EN
  input  logic                 cfg_inv,
`endif
  input  logic                 cfg_commit,
  bit_reorder_stream_if.slave  bus
);

  localparam int EXT_W = 2 ** SEL_WIDTH;

  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64 || EXT_W < DATA_WIDTH) begin : g_param_check
      $error("bit_reorder_stream: need 1 <= DATA_WIDTH <= 64 and 2**SEL_WIDTH >= DATA_WIDTH");
    end
  endgenerate

  logic [SEL_WIDTH-1:0]  shadow_map_reg  [DATA_WIDTH];
  logic [SEL_WIDTH-1:0]  shadow_map_next [DATA_WIDTH];
  logic [SEL_WIDTH-1:0]  active_map_reg  [DATA_WIDTH];
  logic [EXT_W-1:0]      in_ext;
  logic [DATA_WIDTH-1:0] perm_data;
  logic                  accept;
  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_reg, out_next;

  // Zero-padding up to 2**SEL_WIDTH makes any selector >= DATA_WIDTH read a 0 bit.
  assign in_ext = EXT_W'(bus.in);

`ifdef BIT_REORDER_INVERT_EN
  logic [DATA_WIDTH-1:0] shadow_inv_reg, shadow_inv_next, active_inv_reg;
`endif

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      // Only indices below DATA_WIDTH can match, so out-of-range writes fall through.
      assign shadow_map_next[gi] = (cfg_wr && cfg_idx == SEL_WIDTH'(gi)) ? cfg_sel
                                                                         : shadow_map_reg[gi];
`ifdef BIT_REORDER_INVERT_EN
      assign shadow_inv_next[gi] = (cfg_wr && cfg_idx == SEL_WIDTH'(gi)) ? cfg_inv
                                                                         : shadow_inv_reg[gi];
      assign perm_data[gi]       = in_ext[active_map_reg[gi]] ^ active_inv_reg[gi];
`else
      assign perm_data[gi]       = in_ext[active_map_reg[gi]];
`endif
    end
  endgenerate

  // Commit copies the post-write shadow, so a same-cycle write is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        shadow_map_reg[i] <= SEL_WIDTH'(i);
        active_map_reg[i] <= SEL_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        shadow_map_reg[i] <= shadow_map_next[i];
        if (cfg_commit) begin
          active_map_reg[i] <= shadow_map_next[i];
        end
      end
    end
  end

`ifdef BIT_REORDER_INVERT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_inv_reg <= '0;
      active_inv_reg <= '0;
    end else begin
      shadow_inv_reg <= shadow_inv_next;
      if (cfg_commit) begin
        active_inv_reg <= shadow_inv_next;
      end
    end
  end
`endif

  assign bus.in_ready  = ~out_valid_reg | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out       = out_reg;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_next       = out_reg;
    if (accept) begin
      out_valid_next = 1'b1;
      out_next       = en ? perm_data : bus.in;
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_reg       <= out_next;
    end
  end

endmodule

// File: tb/tb_bit_reorder_stream.sv
// Bench for bit_reorder_stream: directed cases plus a randomized run against a transaction-level model.
// Optional BIT_REORDER_INVERT_EN build adds the inversion case.
module tb_bit_reorder_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, cfg_wr, cfg_commit;
  logic [4:0] cfg_idx, cfg_sel;
  logic       en16, cfg16_wr, cfg16_commit;
  logic [4:0] cfg16_idx, cfg16_sel;
`ifdef BIT_REORDER_INVERT_EN
  logic       cfg_inv, cfg16_inv;
`endif

  bit_reorder_stream_if #(.DATA_WIDTH(32)) bus32 ();
  bit_reorder_stream_if #(.DATA_WIDTH(16)) bus16 ();

  bit_reorder_stream #(.DATA_WIDTH(32), .SEL_WIDTH(5)) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_wr     (cfg_wr),
    .cfg_idx    (cfg_idx),
    .cfg_sel    (cfg_sel),
`ifdef BIT_REORDER_INVERT_EN
    .cfg_inv    (cfg_inv),
`endif
    .cfg_commit (cfg_commit),
    .bus        (bus32.slave)
  );

  bit_reorder_stream #(.DATA_WIDTH(16), .SEL_WIDTH(5)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en16),
    .cfg_wr     (cfg16_wr),
    .cfg_idx    (cfg16_idx),
    .cfg_sel    (cfg16_sel),
`ifdef BIT_REORDER_INVERT_EN
    .cfg_inv    (cfg16_inv),
`endif
    .cfg_commit (cfg16_commit),
    .bus        (bus16.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;
  bit check_on = 1'b0;

  // Reference for dut32: tables as plain arrays, and beats in flight as a queue of expected words.
  int          sh_map  [32];
  int          act_map [32];
  bit          sh_inv  [32];
  bit          act_inv [32];
  logic [31:0] q [$];
  logic [31:0] last_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_beat(input logic [31:0] d, input logic e);
    logic [31:0] r;
    r = d;
    if (e) begin
      for (int i = 0; i < 32; i++) begin
        r[i] = ((act_map[i] < 32) ? d[act_map[i]] : 1'b0) ^ act_inv[i];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      sh_map[i]  = i;
      act_map[i] = i;
      sh_inv[i]  = 1'b0;
      act_inv[i] = 1'b0;
    end
    q.delete();
    last_out = '0;
  endtask

  initial begin
    logic [31:0] beat;
    bit          pop, acc;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        pop  = (q.size() > 0) && bus32.out_ready;
        acc  = bus32.in_valid && ((q.size() == 0) || bus32.out_ready);
        beat = model_beat(bus32.in, en);
        if (pop) begin
          last_out = q.pop_front();
          n_beats++;
          $display("[TB] beat %0d delivered %h", n_beats, last_out);
        end
        if (acc) q.push_back(beat);
        if (cfg_wr && cfg_idx < 32) begin
          sh_map[cfg_idx] = cfg_sel;
`ifdef BIT_REORDER_INVERT_EN
          sh_inv[cfg_idx] = cfg_inv;
`endif
        end
        if (cfg_commit) begin
          act_map = sh_map;
          act_inv = sh_inv;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of dut32 against the model, after inputs for the cycle settle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (check_on && rst_n) begin
        check("out_valid", {31'b0, bus32.out_valid}, {31'b0, q.size() > 0});
        check("out", bus32.out, (q.size() > 0) ? q[0] : last_out);
        check("in_ready", {31'b0, bus32.in_ready},
              {31'b0, (q.size() == 0) || bus32.out_ready});
      end
    end
  end

  task automatic send32(input logic [31:0] d, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.in       = d;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #2;
    check(name, bus32.out, exp);
  endtask

  task automatic send16(input logic [15:0] d, input logic [15:0] exp, input string name);
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.in       = d;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    #2;
    check(name, {16'b0, bus16.out}, {16'b0, exp});
  endtask

  task automatic cfg32(input int idx, input int sel, input bit inv, input bit commit);
    @(negedge clk);
    cfg_wr     = 1'b1;
    cfg_idx    = 5'(idx);
    cfg_sel    = 5'(sel);
    cfg_commit = commit;
`ifdef BIT_REORDER_INVERT_EN
    cfg_inv    = inv;
`else
    if (inv) $display("[TB] inversion request ignored in this build");
`endif
    @(negedge clk);
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic cfg16(input int idx, input int sel);
    @(negedge clk);
    cfg16_wr     = 1'b1;
    cfg16_idx    = 5'(idx);
    cfg16_sel    = 5'(sel);
    cfg16_commit = 1'b1;
    @(negedge clk);
    cfg16_wr     = 1'b0;
    cfg16_commit = 1'b0;
  endtask

  initial begin
    int t2_sel [7];
    t2_sel = '{5, 6, 7, 1, 2, 3, 4};
    rst_n = 1'b0;
    en = 1'b1; cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_idx = '0; cfg_sel = '0;
    en16 = 1'b1; cfg16_wr = 1'b0; cfg16_commit = 1'b0; cfg16_idx = '0; cfg16_sel = '0;
`ifdef BIT_REORDER_INVERT_EN
    cfg_inv = 1'b0; cfg16_inv = 1'b0;
`endif
    bus32.in_valid = 1'b0; bus32.in = '0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in = '0; bus16.out_ready = 1'b1;

    #12;
    check("rst_out_valid", {31'b0, bus32.out_valid}, 32'd0);
    check("rst_out", bus32.out, 32'd0);
    check("rst_in_ready", {31'b0, bus32.in_ready}, 32'd1);
    check("rst16_out_valid", {31'b0, bus16.out_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    check_on = 1'b1;

    send32(32'hF0F0F0F0, 32'hF0F0F0F0, "t1_identity");

`ifdef BIT_REORDER_INVERT_EN
    cfg32(0, 0, 1'b1, 1'b1);
    send32(32'h00000000, 32'h00000001, "inv_bit0");
    cfg32(0, 0, 1'b0, 1'b1);
`endif

    // Final write shares its edge with the commit, which must include it.
    for (int i = 0; i < 7; i++) begin
      cfg32(i + 1, t2_sel[i], 1'b0, i == 6);
    end
    send32(32'hF0F0F0F0, 32'hF0F0F08E, "t2_map");

    en = 1'b0;
    send32(32'hF0F0F0F0, 32'hF0F0F0F0, "t3_bypass");

    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.in = 32'h12345678; bus32.out_ready = 1'b0;
    @(negedge clk);
    bus32.in = 32'h9ABCDEF0;
    #2;
    check("t4_stall_in_ready", {31'b0, bus32.in_ready}, 32'd0);
    check("t4_hold_first", bus32.out, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #2;
    check("t4_second", bus32.out, 32'h9ABCDEF0);
    check("t4_second_valid", {31'b0, bus32.out_valid}, 32'd1);
    en = 1'b1;

    cfg32(0, 31, 1'b0, 1'b0);
    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.in = 32'hF0F0F0F0; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    #2;
    check("t5_a_old_map", bus32.out, 32'hF0F0F08E);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #2;
    check("t5_b_new_map", bus32.out, 32'hF0F0F08F);

    repeat (1500) begin
      @(negedge clk);
      bus32.in_valid  = ($urandom_range(0, 3) != 0);
      bus32.in        = $urandom;
      bus32.out_ready = ($urandom_range(0, 2) != 0);
      en              = ($urandom_range(0, 3) != 0);
      cfg_wr          = ($urandom_range(0, 3) == 0);
      cfg_idx         = 5'($urandom_range(0, 31));
      cfg_sel         = 5'($urandom_range(0, 31));
      cfg_commit      = ($urandom_range(0, 7) == 0);
`ifdef BIT_REORDER_INVERT_EN
      cfg_inv         = ($urandom_range(0, 3) == 0);
`endif
    end
    @(negedge clk);
    bus32.in_valid = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0; bus32.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    cfg16(3, 20);
    send16(16'hFFFF, 16'hFFF7, "t6_sel_out_of_range");
    cfg16(20, 0);
    send16(16'hFFFE, 16'hFFF6, "t6_idx_out_of_range");
    @(negedge clk);
    bus16.out_ready = 1'b0;
    send16(16'h1234, 16'h1234, "t6_stalled_beat");
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", {31'b0, bus16.out_valid}, 32'd0);
    check("t6_rst_out", {16'b0, bus16.out}, 32'd0);
    check("t6_rst_in_ready", {31'b0, bus16.in_ready}, 32'd1);
    check("t6_rst32_out_valid", {31'b0, bus32.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    send32(32'hF0F0F0F0, 32'hF0F0F0F0, "rst_restores_identity");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
